// File: rtl/lane_judge_if.sv
// lane_judge_if: link between a lane judge and its tile generator.
// The judge launches/retires tiles and sets speed; the generator reports tile position.
`timescale 1ns/1ps
interface lane_judge_if;
  logic       newNote;
  logic       kill;
  logic [3:0] speed;
  logic [9:0] TileY;
  logic [9:0] TileS;

  modport master (
    output newNote,
    output kill,
    output speed,
    input  TileY,
    input  TileS
  );

  modport slave (
    input  newNote,
    input  kill,
    input  speed,
    output TileY,
    output TileS
  );
endinterface

// File: rtl/lane_judge.sv
// lane_judge: per-lane game controller for a falling-tile rhythm game.
// Spawns tiles, judges key presses as hit/miss, keeps score and speed.
`timescale 1ns/1ps
module lane_judge #(
  parameter logic [7:0] LANE_KEY       = 8'h04,
  parameter int         HIT_TOP        = 300,
  parameter int         Y_MAX          = 479,
  parameter int         SPAWN_GAP      = 30,
  parameter int         MAX_MISS       = 3,
  parameter int         HITS_PER_SPEED = 8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  keycode,
  lane_judge_if.master tile,
  output logic [15:0] score,
  output logic [1:0]  misses,
  output logic        game_over
);

  localparam int HW =
    (HITS_PER_SPEED > 1) ? $clog2(HITS_PER_SPEED) : 1;
  localparam int GW =
    (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LD =
    GW'(SPAWN_GAP - 1);
  localparam logic [HW-1:0] HIT_LAST =
    HW'(HITS_PER_SPEED - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SPAWN,
    S_FALL,
    S_HIT,
    S_MISS,
    S_OVER
  } state_t;

  state_t        state;
  logic [GW-1:0] gap;
  logic [HW-1:0] hit_cnt;
  logic [7:0]    prev_key;
  logic [3:0]    speed_q;
  logic          new_note_q;
  logic          kill_q;

  logic [10:0]   bottom;
  logic          press;
  logic          at_bot;
  logic          in_win;
  logic          hit_wrap;
  logic [1:0]    miss_inc;

  assign tile.newNote = new_note_q;
  assign tile.kill    = kill_q;
  assign tile.speed   = speed_q;

  // 11-bit sum so a tile near the bottom never wraps into the window
  assign bottom   = {1'b0, tile.TileY}
                  + {1'b0, tile.TileS};
  assign at_bot   = bottom >= 11'(Y_MAX);
  assign in_win   = bottom >= 11'(HIT_TOP);
  assign press    = (keycode == LANE_KEY)
                 && (prev_key != LANE_KEY);
  assign hit_wrap = hit_cnt == HIT_LAST;
  assign miss_inc = misses + 2'd1;

  always_ff @(posedge frame_clk) begin
    prev_key   <= keycode;
    new_note_q <= 1'b0;
    kill_q     <= 1'b0;
    if (Reset) begin
      state     <= S_IDLE;
      gap       <= '0;
      hit_cnt   <= '0;
      speed_q   <= '0;
      score     <= '0;
      misses    <= '0;
      game_over <= 1'b0;
      prev_key  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            gap   <= GAP_LD;
          end
        end
        S_WAIT: begin
          if (gap == '0) begin
            state      <= S_SPAWN;
            new_note_q <= 1'b1;
          end else begin
            gap <= gap - 1'b1;
          end
        end
        S_SPAWN: begin
          state <= S_FALL;
        end
        S_FALL: begin
          // reaching the bottom beats a late press
          if (at_bot) begin
            state  <= S_MISS;
            kill_q <= 1'b1;
          end else if (press && in_win) begin
            state  <= S_HIT;
            kill_q <= 1'b1;
          end
        end
        S_HIT: begin
          if (score != 16'hFFFF)
            score <= score + 16'd1;
          hit_cnt <= hit_wrap ? '0
                              : hit_cnt + 1'b1;
          if (hit_wrap && speed_q != 4'hF)
            speed_q <= speed_q + 4'd1;
          state <= S_WAIT;
          gap   <= GAP_LD;
        end
        S_MISS: begin
          misses <= miss_inc;
          if (miss_inc == 2'(MAX_MISS)) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else begin
            state <= S_WAIT;
            gap   <= GAP_LD;
          end
        end
        S_OVER: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            speed_q   <= '0;
            hit_cnt   <= '0;
            game_over <= 1'b0;
            state     <= S_WAIT;
            gap       <= GAP_LD;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_judge.sv
// tb_lane_judge: random-stimulus bench for lane_judge.
// Plays the tile generator and compares every cycle against a lane model.
`timescale 1ns/1ps
module tb_lane_judge;
  localparam logic [7:0] LANE = 8'h04;
  localparam int HIT_TOP = 300;
  localparam int Y_MAX   = 479;
  localparam int GAP     = 30;
  localparam int MAXM    = 3;
  localparam int HPS     = 8;
  localparam int PL_NONE = 0;
  localparam int PL_TAP  = 1;
  localparam int PL_HOLD = 2;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  keycode;
  logic [15:0] score;
  logic [1:0]  misses;
  logic        game_over;

  lane_judge_if tif();

  lane_judge dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .start     (start),
    .keycode   (keycode),
    .tile      (tif),
    .score     (score),
    .misses    (misses),
    .game_over (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  int vectors     = 0;
  int miscompares = 0;

  // lane model: which phase the lane is in, counted in plain integers
  bit         r_idle    = 1'b1;
  int         r_gap     = -1;
  bit         r_launch  = 1'b0;
  bit         r_drop    = 1'b0;
  int         r_verdict = 0;
  bit         r_over    = 1'b0;
  int         r_hits    = 0;
  int         r_miss    = 0;
  logic [7:0] r_key     = 8'h00;

  task automatic expect_eq(input string tag,
                           input logic [15:0] got,
                           input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic ref_step(input bit st, input logic [7:0] kc,
                          input int y, input int s,
                          input bit rs);
    bit edge_k;
    int bot;
    edge_k = (kc == LANE) && (r_key != LANE);
    bot    = y + s;
    if (rs) begin
      r_idle = 1'b1; r_gap = -1; r_launch = 1'b0;
      r_drop = 1'b0; r_verdict = 0; r_over = 1'b0;
      r_hits = 0; r_miss = 0;
    end else if (r_idle) begin
      if (st) begin r_idle = 1'b0; r_gap = 0; end
    end else if (r_gap >= 0) begin
      r_gap++;
      if (r_gap == GAP) begin r_gap = -1; r_launch = 1'b1; end
    end else if (r_launch) begin
      r_launch = 1'b0; r_drop = 1'b1;
    end else if (r_drop) begin
      if (bot >= Y_MAX) begin
        r_drop = 1'b0; r_verdict = 2;
      end else if (edge_k && bot >= HIT_TOP) begin
        r_drop = 1'b0; r_verdict = 1;
      end
    end else if (r_verdict == 1) begin
      r_hits++; r_verdict = 0; r_gap = 0;
    end else if (r_verdict == 2) begin
      r_miss++; r_verdict = 0;
      if (r_miss == MAXM) r_over = 1'b1;
      else r_gap = 0;
    end else if (r_over) begin
      if (st) begin
        r_over = 1'b0; r_hits = 0; r_miss = 0; r_gap = 0;
      end
    end
    r_key = rs ? 8'h00 : kc;
  endtask

  task automatic step(input bit st, input logic [7:0] kc,
                      input int y, input int s, input bit rs);
    int sc, sp;
    Reset     = rs;
    start     = st;
    keycode   = kc;
    tif.TileY = 10'(y);
    tif.TileS = 10'(s);
    @(posedge frame_clk);
    ref_step(st, kc, y, s, rs);
    #1;
    sc = (r_hits > 65535) ? 65535 : r_hits;
    sp = (r_hits / HPS > 15) ? 15 : r_hits / HPS;
    expect_eq("newNote",   16'(tif.newNote), 16'(r_launch));
    expect_eq("kill",      16'(tif.kill),    16'(r_verdict != 0));
    expect_eq("score",     score,            16'(sc));
    expect_eq("speed",     16'(tif.speed),   16'(sp));
    expect_eq("misses",    16'(misses),      16'(r_miss));
    expect_eq("game_over", 16'(game_over),   16'(r_over));
  endtask

  function automatic logic [7:0] pick_key(input bit noise,
                                          input bit falling);
    logic [7:0] k;
    k = 8'h00;
    if (noise) begin
      case ($urandom_range(3, 0))
        0:       k = 8'h00;
        1:       k = 8'h05;
        2:       k = 8'h1A;
        default: k = falling ? 8'h07 : LANE;
      endcase
    end
    return k;
  endfunction

  // acts as the tile generator until the judge retires the tile
  task automatic run_tile(input int plan, input int pk,
                          input int s, input bit noise,
                          output int spawn_at);
    int k;
    int n;
    int y;
    bit done;
    bit st;
    logic [7:0] kc;
    k = -1; n = 0; done = 1'b0; spawn_at = -1;
    while (!done && n < 400) begin
      kc = pick_key(noise, k >= 0);
      if (k >= 0 && plan == PL_TAP && k == pk) kc = LANE;
      if (k >= 0 && plan == PL_HOLD && k >= pk) kc = LANE;
      st = noise && ($urandom_range(15, 0) == 0);
      y  = (k < 0) ? 0 : ((4 * k > 1000) ? 1000 : 4 * k);
      step(st, kc, y, s, 1'b0);
      n++;
      if (tif.kill === 1'b1) done = 1'b1;
      else if (tif.newNote === 1'b1) begin
        k = 0; spawn_at = n;
      end else if (k >= 0) k++;
    end
    if (!done) expect_eq("tile_timeout", 16'(n), 16'd0);
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 0, 75, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp;
    int s;
    int lo;
    int notes;
    Reset = 1'b1; start = 1'b0; keycode = 8'h00;
    tif.TileY = '0; tif.TileS = 10'd75;

    step(1'b0, 8'h00, 0, 75, 1'b1);
    step(1'b0, 8'h00, 0, 75, 1'b1);
    expect_eq("rst_score", score, 16'd0);
    expect_eq("rst_speed", 16'(tif.speed), 16'd0);
    expect_eq("rst_over",  16'(game_over), 16'd0);
    repeat (3) idle_step();

    // first game: hit, early hold, bottom+press, silent miss
    step(1'b1, 8'h00, 0, 75, 1'b0);
    run_tile(PL_TAP, 58, 75, 1'b0, sp);
    expect_eq("spawn_gap", 16'(sp), 16'd30);
    idle_step();
    expect_eq("hit1_score", score, 16'd1);
    run_tile(PL_HOLD, 25, 75, 1'b0, sp);
    idle_step();
    expect_eq("hold_score",  score,        16'd1);
    expect_eq("hold_misses", 16'(misses),  16'd1);
    run_tile(PL_TAP, 101, 75, 1'b0, sp);
    idle_step();
    expect_eq("bot_score",  score,       16'd1);
    expect_eq("bot_misses", 16'(misses), 16'd2);
    run_tile(PL_NONE, 0, 75, 1'b0, sp);
    idle_step();
    expect_eq("over_flag",   16'(game_over), 16'd1);
    expect_eq("over_misses", 16'(misses),    16'd3);
    repeat (5) idle_step();
    expect_eq("over_hold", score, 16'd1);

    // restart from OVER, then five hits and a reset mid-fall
    step(1'b1, 8'h00, 0, 75, 1'b0);
    expect_eq("restart_score", score, 16'd0);
    expect_eq("restart_over",  16'(game_over), 16'd0);
    run_tile(PL_TAP, 60, 75, 1'b0, sp);
    expect_eq("restart_gap", 16'(sp), 16'd30);
    for (int i = 0; i < 4; i++)
      run_tile(PL_TAP, 70 + i, 75, 1'b0, sp);
    idle_step();
    expect_eq("five_hits", score, 16'd5);
    for (int i = 0; i < 100 && tif.newNote !== 1'b1; i++)
      idle_step();
    for (int k = 0; k < 10; k++)
      step(1'b0, 8'h00, 4 * k, 75, 1'b0);
    step(1'b0, 8'h00, 40, 75, 1'b1);
    expect_eq("mid_rst_score", score, 16'd0);
    expect_eq("mid_rst_kill",  16'(tif.kill), 16'd0);
    notes = 0;
    for (int i = 0; i < 40; i++) begin
      idle_step();
      if (tif.newNote === 1'b1) notes++;
    end
    expect_eq("idle_no_spawn", 16'(notes), 16'd0);

    // long run of hits to saturate speed
    step(1'b1, 8'h00, 0, 75, 1'b0);
    for (int i = 0; i < 130; i++) begin
      s  = ($urandom_range(1, 0) == 0) ? 75 : 76;
      lo = (s == 76) ? 56 : 57;
      run_tile(PL_TAP, int'($urandom_range(100, lo)), s, 1'b1, sp);
      if (i == 7) begin
        idle_step();
        expect_eq("speed_8", 16'(tif.speed), 16'd1);
      end
    end
    idle_step();
    expect_eq("score_130", score, 16'd130);
    expect_eq("speed_sat", 16'(tif.speed), 16'd15);

    // random mix of plans, restarting whenever the game ends
    for (int i = 0; i < 40; i++) begin
      if (r_over) step(1'b1, 8'h00, 0, 75, 1'b0);
      s = ($urandom_range(1, 0) == 0) ? 75 : 76;
      run_tile(int'($urandom_range(2, 0)),
               int'($urandom_range(105, 0)), s, 1'b1, sp);
    end
    repeat (3) idle_step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
